mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator that sits between the execute stage and the byte-addressable data memory. It drives the memory's read/write/func3/address/write-data port and takes its read data back. It accepts one request at a time from the pipeline. Naturally aligned accesses complete as a single memory beat. Misaligned halfword and word accesses are split into a sequence of byte beats, reassembled, and sign- or zero-extended. The pipeline gets a single-cycle response pulse and is stalled while the unit is busy.

## Interface
- ADDR_W, 12, memory byte-address width; all address arithmetic wraps modulo 2^ADDR_W.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE and not in reset.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; illegal func3.
- stall  out  1  high from the acceptance cycle through the last beat (state != IDLE and != RESP).
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable; the memory commits on the rising edge.
- mem_func3  out  3  width code presented to memory.
- mem_addr  out  ADDR_W  beat address.
- mem_wdata  out  32  beat write data.
- mem_rdata  in  32  combinational memory read data.

## Operation
- States: IDLE, BEAT, RESP.
- **Acceptance**
  - Handshake is req_valid && req_ready at a rising edge.
  - On acceptance, latch we/func3/addr/wdata.
  - Classify the request:
    - illegal: store func3 not in {000,001,010}, or load func3 not in {000,001,010,100,101};
    - aligned: byte, half with addr[0]=0, or word with addr[1:0]=00;
    - otherwise misaligned.
  - Illegal: go straight to RESP with resp_err=1 and no memory activity.
  - Legal: go to BEAT with beat counter k=0 and beat count N = 1 (aligned), 2 (misaligned half) or 4 (misaligned word).
- **BEAT, aligned**
  - mem_func3 = latched func3, mem_addr = latched addr.
  - mem_read = !we; mem_write = we.
  - mem_wdata = latched wdata.
  - Load result = mem_rdata as returned; the memory performs the extension.
- **BEAT, misaligned**
  - mem_addr = addr + k (wraps).
  - Loads use mem_func3 = 100 (BU). Capture mem_rdata[7:0] into assembly bits [8k+7:8k].
  - Stores use mem_func3 = 000 (SB) with mem_wdata = {24'b0, wdata[8k+7:8k]}.
  - After the final beat (k=N-1), extend the assembled value: func3 001 sign-extends from bit 15, 101 zero-extends, word is unchanged.
- **RESP**
  - resp_valid=1 for exactly one cycle; go to IDLE.
- **Outputs outside BEAT**
  - All mem_* outputs are 0.
  - resp_rdata holds its last value while resp_valid=0.
- **Reset**
  - Reset values: state IDLE, k=0; resp_valid, resp_rdata, resp_err, stall, mem_read, mem_write, mem_func3, mem_addr and mem_wdata all 0.
  - req_ready=0 while rst=1.
  - mem_write is gated by !rst combinationally, so no store byte is committed in a cycle where rst=1.
  - Reset mid-sequence abandons the request. Bytes already written stay written; no response is issued.

## Timing
- Acceptance edge is T0.
- Aligned: beat in cycle T0+1, resp_valid in T0+2, req_ready high again in T0+3.
- Misaligned half: beats in T0+1 and T0+2, resp_valid in T0+3.
- Misaligned word: beats in T0+1..T0+4, resp_valid in T0+5.
- Illegal: resp_valid and resp_err in T0+1.
- Load data is sampled at the end of each beat cycle; the memory read is combinational.
- resp_rdata is registered and valid in the resp_valid cycle.
- req_valid while req_ready=0 is ignored; the pipeline must hold it.
- Simultaneous rst and req_valid: reset wins, request not accepted.

## Test plan
- Aligned LW at 500, mem[500..503] holding 32'd17:
  - mem_read=1, mem_func3=010, mem_addr=500 in T0+1 only;
  - resp_valid with resp_rdata=17 in T0+2.
- Misaligned LW at 501, mem[500..507] = 11,22,33,44,55,66,77,88 (hex):
  - four beats, mem_addr 501..504, mem_func3=100;
  - resp_rdata=0x55443322 in T0+5.
- Misaligned LH at 505 with mem[505]=0x34, mem[506]=0xF2:
  - resp_rdata=0xFFFFF234;
  - the same access as LHU returns 0x0000F234; both respond in T0+3.
- Misaligned SW of 0xA1B2C3D4 at 0xFFE:
  - byte writes 0xFFE=D4, 0xFFF=C3, 0x000=B2, 0x001=A1 (wrap);
  - resp_rdata=0 in T0+5.
- Same SW, rst asserted for one cycle during beat k=2:
  - only 0xFFE and 0xFFF are written, no resp_valid;
  - req_ready=1 the cycle after rst drops.
- Load with func3=011:
  - resp_valid=1, resp_err=1, resp_rdata=0 in T0+1;
  - mem_read and mem_write never assert.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator between execute and byte-addressable data memory.
// Aligned accesses take one memory beat; misaligned H/W accesses are split into byte beats.
//   state  | meaning
//   IDLE   | ready for a request
//   BEAT   | driving memory beat k of N
//   RESP   | one-cycle completion pulse
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_we, r_mis, r_err;
  logic [2:0]        r_func3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_asm, r_rdata;
  logic [1:0]        r_k, r_last;

  logic        w_accept, w_legal, w_aligned, w_last_beat;
  logic [1:0]  w_nlast;
  logic [4:0]  w_byte_sh;
  logic [31:0] w_wshift, w_asm_next, w_ext, w_load_result;

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = (r_state == S_RESP) && !rst;
  assign resp_err   = resp_valid && r_err;
  assign stall      = (r_state == S_BEAT) && !rst;
  assign resp_rdata = r_rdata;

  assign w_accept = req_valid && req_ready;

  always_comb begin
    w_legal = 1'b0;
    if (req_we) w_legal = req_func3 inside {3'b000, 3'b001, 3'b010};
    else        w_legal = req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  always_comb begin
    w_aligned = 1'b0;
    w_nlast   = 2'd0;
    case (req_func3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = !req_addr[0];
      2'b10:   w_aligned = (req_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
    if (!w_aligned) w_nlast = (req_func3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  end

  assign w_last_beat = (r_state == S_BEAT) && (r_k == r_last);
  assign w_byte_sh   = {r_k, 3'b000};
  assign w_wshift    = r_wdata >> w_byte_sh;
  assign w_asm_next  = r_asm | ({24'b0, mem_rdata[7:0]} << w_byte_sh);

  // Assembled halfwords are extended here; aligned loads come back already extended.
  always_comb begin
    case (r_func3)
      3'b001:  w_ext = {{16{w_asm_next[15]}}, w_asm_next[15:0]};
      3'b101:  w_ext = {16'b0, w_asm_next[15:0]};
      default: w_ext = w_asm_next;
    endcase
  end

  assign w_load_result = r_mis ? w_ext : mem_rdata;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = 3'b000;
    mem_addr  = '0;
    mem_wdata = 32'b0;
    if ((r_state == S_BEAT) && !rst) begin
      mem_read  = !r_we;
      mem_write = r_we;
      if (r_mis) begin
        mem_func3 = r_we ? 3'b000 : 3'b100;
        mem_addr  = r_addr + ADDR_W'(r_k);
        mem_wdata = {24'b0, w_wshift[7:0]};
      end else begin
        mem_func3 = r_func3;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_legal ? S_BEAT : S_RESP;
      S_BEAT:  if (w_last_beat) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_last  <= 2'd0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_func3 <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'b0;
      r_asm   <= 32'b0;
      r_rdata <= 32'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_func3 <= req_func3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_k     <= 2'd0;
        r_last  <= w_nlast;
        r_mis   <= !w_aligned;
        r_err   <= !w_legal;
        r_asm   <= 32'b0;
        if (!w_legal) r_rdata <= 32'b0;
      end
      if (r_state == S_BEAT) begin
        r_k <= r_k + 2'd1;
        if (!r_we && r_mis) r_asm <= w_asm_next;
        if (w_last_beat) r_rdata <= r_we ? 32'b0 : w_load_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte memory model and a queue-based scoreboard.
// Responses and memory beats are checked by a negedge monitor against queued expectations.
module tb_mem_access_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready, req_we;
  logic [2:0]    req_func3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err, stall;
  logic [31:0]   resp_rdata;
  logic          mem_read, mem_write;
  logic [2:0]    mem_func3;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [7:0] mem [4096];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_func3)
        3'b000: mem[mem_addr] <= mem_wdata[7:0];
        3'b001: begin
          mem[mem_addr]         <= mem_wdata[7:0];
          mem[mem_addr + 12'd1] <= mem_wdata[15:8];
        end
        3'b010: begin
          mem[mem_addr]         <= mem_wdata[7:0];
          mem[mem_addr + 12'd1] <= mem_wdata[15:8];
          mem[mem_addr + 12'd2] <= mem_wdata[23:16];
          mem[mem_addr + 12'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    b0 = mem[mem_addr];
    b1 = mem[mem_addr + 12'd1];
    b2 = mem[mem_addr + 12'd2];
    b3 = mem[mem_addr + 12'd3];
    case (mem_func3)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b100:  mem_rdata = {24'b0, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b101:  mem_rdata = {16'b0, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      default: mem_rdata = 32'b0;
    endcase
  end

  typedef struct {logic [31:0] rdata; logic err; int cyc;} resp_t;
  typedef struct {logic [AW-1:0] addr; logic [2:0] f3; logic rd; logic wr; logic [31:0] wdata; int cyc;} beat_t;
  resp_t rq[$];
  beat_t bq[$];
  resp_t re;
  beat_t be;
  int total = 0, bad = 0;

  always @(negedge clk) begin
    if (resp_valid) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp got rdata=%h err=%b cyc=%0d want no response", resp_rdata, resp_err, cyc);
      end else begin
        re = rq.pop_front();
        if (resp_rdata !== re.rdata || resp_err !== re.err || cyc != re.cyc) begin
          bad++;
          $display("FAIL resp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                   resp_rdata, resp_err, cyc, re.rdata, re.err, re.cyc);
        end
      end
    end
    if (mem_read || mem_write) begin
      total++;
      if (bq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got addr=%h f3=%b rd=%b wr=%b cyc=%0d want no beat",
                 mem_addr, mem_func3, mem_read, mem_write, cyc);
      end else begin
        be = bq.pop_front();
        if (mem_addr !== be.addr || mem_func3 !== be.f3 || mem_read !== be.rd || mem_write !== be.wr ||
            (be.wr && mem_wdata !== be.wdata) || stall !== 1'b1 || cyc != be.cyc) begin
          bad++;
          $display("FAIL beat got addr=%h f3=%b rd=%b wr=%b wd=%h stall=%b cyc=%0d want addr=%h f3=%b rd=%b wr=%b wd=%h stall=1 cyc=%0d",
                   mem_addr, mem_func3, mem_read, mem_write, mem_wdata, stall, cyc,
                   be.addr, be.f3, be.rd, be.wr, be.wdata, be.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Returns c: cycle count just before the acceptance edge, so beat k lands at c+1+k.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, output int c);
    int n;
    @(negedge clk);
    req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c = cyc - 1;
  endtask

  task automatic push_beat(input logic [AW-1:0] a, input logic [2:0] f3, input logic rd,
                           input logic [31:0] wd, input int c);
    bq.push_back('{addr: a, f3: f3, rd: rd, wr: !rd, wdata: wd, cyc: c});
  endtask

  task automatic push_bytes(input logic [AW-1:0] a, input int n, input logic rd,
                            input logic [31:0] wd, input int c);
    logic [31:0] sh;
    for (int k = 0; k < n; k++) begin
      sh = wd >> (8 * k);
      push_beat(a + AW'(k), rd ? 3'b100 : 3'b000, rd, {24'b0, sh[7:0]}, c + 1 + k);
    end
  endtask

  task automatic push_resp(input logic [31:0] d, input logic e, input int c);
    rq.push_back('{rdata: d, err: e, cyc: c});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      chk("drain_timeout", rq.size() + bq.size(), 32'd0);
      rq.delete();
      bq.delete();
    end
  endtask

  int c;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000; req_addr = '0; req_wdata = 32'b0;

    // Reset state, with a request held during reset that must not be accepted.
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_func3 = 3'b010; req_addr = 12'h100;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_ctl", {mem_read, mem_write, mem_func3, mem_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_stall", {31'b0, stall}, 32'd0);

    // Aligned LW at 500.
    mem[500] = 8'd17; mem[501] = 8'd0; mem[502] = 8'd0; mem[503] = 8'd0;
    issue(1'b0, 3'b010, 12'd500, 32'h0, c);
    push_beat(12'd500, 3'b010, 1'b1, 32'h0, c + 1);
    push_resp(32'd17, 1'b0, c + 2);
    while (cyc < c + 2) @(negedge clk);
    chk("lw_ready_t2", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("lw_ready_t3", {31'b0, req_ready}, 32'd1);
    wait_done();

    // Misaligned LW at 501.
    mem[500] = 8'h11; mem[501] = 8'h22; mem[502] = 8'h33; mem[503] = 8'h44;
    mem[504] = 8'h55; mem[505] = 8'h66; mem[506] = 8'h77; mem[507] = 8'h88;
    issue(1'b0, 3'b010, 12'd501, 32'hDEADBEEF, c);
    push_bytes(12'd501, 4, 1'b1, 32'h0, c);
    push_resp(32'h55443322, 1'b0, c + 5);
    wait_done();

    // Misaligned LH and LHU at 505.
    mem[505] = 8'h34; mem[506] = 8'hF2;
    issue(1'b0, 3'b001, 12'd505, 32'h0, c);
    push_bytes(12'd505, 2, 1'b1, 32'h0, c);
    push_resp(32'hFFFFF234, 1'b0, c + 3);
    wait_done();
    issue(1'b0, 3'b101, 12'd505, 32'h0, c);
    push_bytes(12'd505, 2, 1'b1, 32'h0, c);
    push_resp(32'h0000F234, 1'b0, c + 3);
    wait_done();

    // Aligned LB: memory-side sign extension passes straight through.
    mem[12'h020] = 8'h80;
    issue(1'b0, 3'b000, 12'h020, 32'h0, c);
    push_beat(12'h020, 3'b000, 1'b1, 32'h0, c + 1);
    push_resp(32'hFFFFFF80, 1'b0, c + 2);
    wait_done();

    // Illegal load func3=011 and illegal store func3=100: error, no memory beats.
    issue(1'b0, 3'b011, 12'h100, 32'h0, c);
    push_resp(32'h0, 1'b1, c + 1);
    wait_done();
    issue(1'b1, 3'b100, 12'h104, 32'h12345678, c);
    push_resp(32'h0, 1'b1, c + 1);
    wait_done();

    // Aligned SH at 0x010.
    issue(1'b1, 3'b001, 12'h010, 32'h1234BEEF, c);
    push_beat(12'h010, 3'b001, 1'b0, 32'h1234BEEF, c + 1);
    push_resp(32'h0, 1'b0, c + 2);
    wait_done();
    @(negedge clk);
    chk("sh_mem", {8'h0, mem[12'h012], mem[12'h011], mem[12'h010]}, 32'h0000BEEF);

    // Misaligned SW wrapping the top of the address space.
    issue(1'b1, 3'b010, 12'hFFE, 32'hA1B2C3D4, c);
    push_bytes(12'hFFE, 4, 1'b0, 32'hA1B2C3D4, c);
    push_resp(32'h0, 1'b0, c + 5);
    wait_done();
    @(negedge clk);
    chk("sw_wrap_mem", {mem[12'h001], mem[12'h000], mem[12'hFFF], mem[12'hFFE]}, 32'hA1B2C3D4);

    // Same SW, reset during beat k=2: only the first two bytes land, no response.
    mem[12'hFFE] = 8'h00; mem[12'hFFF] = 8'h00; mem[12'h000] = 8'h00; mem[12'h001] = 8'h00;
    issue(1'b1, 3'b010, 12'hFFE, 32'hA1B2C3D4, c);
    push_bytes(12'hFFE, 2, 1'b0, 32'hA1B2C3D4, c);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_beats_left", bq.size(), 32'd0);
    chk("abort_mem", {mem[12'h001], mem[12'h000], mem[12'hFFF], mem[12'hFFE]}, 32'h0000C3D4);
    bq.delete();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
